// File: rtl/lane_skid_reg_pkg.sv
// Shared definitions for the lane skid register slice: slot-occupancy state
// encodings and default lane geometry.
package lane_skid_reg_pkg;

    typedef enum logic [1:0] {
        LS_EMPTY = 2'd0,
        LS_ONE   = 2'd1,
        LS_FULL  = 2'd2
    } ls_state_t;

    localparam int DEF_LANES = 4;
    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/lane_slot_reg.sv
// One word slot: striped lane data plus lane mask, with load enable, clear
// and masked capture (inactive lanes are stored as zero).
module lane_slot_reg
    import lane_skid_reg_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clkf,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] d_data,
    input  logic [LANES-1:0]       d_mask,
    output logic [LANES*WIDTH-1:0] q_data,
    output logic [LANES-1:0]       q_mask
);

    logic [LANES*WIDTH-1:0] masked;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        masked = '0;
        for (int i = 0; i < LANES; i++) begin
            if (d_mask[i]) masked[i*WIDTH +: WIDTH] = d_data[i*WIDTH +: WIDTH];
        end
    end

    // NOTE: this is a plain register, not a memory, so it is reset; outputs must read zero after reset.
    always_ff @(posedge clkf) begin
        if (reset || clear) begin
            // NOTE: sequential state uses non-blocking assignments only.
            q_data <= '0;
            q_mask <= '0;
        end else if (load) begin
            q_data <= masked;
            q_mask <= d_mask;
        end
    end

endmodule

// File: rtl/lane_skid_reg.sv
// N-lane ready/valid register slice with a 2-entry skid buffer, synchronous
// flush and a saturating backpressure-cycle counter.
module lane_skid_reg
    import lane_skid_reg_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic                   clkf,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_mask,
    output logic [CNT_W-1:0]       stall_cnt
);

    ls_state_t              state, state_next;
    logic                   in_fire, out_fire;
    logic                   main_load, main_from_skid, skid_load;
    logic [LANES*WIDTH-1:0] skid_data, main_d_data;
    logic [LANES-1:0]       skid_mask, main_d_mask;

    // Handshake flags come straight from the state register.
    assign out_valid = (state != LS_EMPTY);
    assign in_ready  = (state != LS_FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = LS_EMPTY;
        end else begin
            case (state)
                LS_EMPTY: if (in_fire) begin
                    state_next = LS_ONE;
                    main_load  = 1'b1;
                end
                LS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_next = LS_FULL;
                        skid_load  = 1'b1;
                    end else if (out_fire) begin
                        state_next = LS_EMPTY;
                    end
                end
                LS_FULL: if (out_fire) begin
                    state_next     = LS_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_next = LS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clkf) begin
        if (reset) state <= LS_EMPTY;
        else       state <= state_next;
    end

    assign main_d_data = main_from_skid ? skid_data : in_data;
    assign main_d_mask = main_from_skid ? skid_mask : in_mask;

    lane_slot_reg #(.LANES(LANES), .WIDTH(WIDTH)) u_main (
        .clkf   (clkf),
        .reset  (reset),
        .clear  (flush),
        .load   (main_load),
        .d_data (main_d_data),
        .d_mask (main_d_mask),
        .q_data (out_data),
        .q_mask (out_mask)
    );

    lane_slot_reg #(.LANES(LANES), .WIDTH(WIDTH)) u_skid (
        .clkf   (clkf),
        .reset  (reset),
        .clear  (flush),
        .load   (skid_load),
        .d_data (in_data),
        .d_mask (in_mask),
        .q_data (skid_data),
        .q_mask (skid_mask)
    );

    // Debug counter survives flush; only reset clears it.
    always_ff @(posedge clkf) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_lane_skid_reg.sv
// Directed bench for lane_skid_reg (4 lanes x 8 bits, 4-bit stall counter).
module tb_lane_skid_reg;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                   clkf = 1'b0;
    logic                   reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LANES*WIDTH-1:0] in_data, out_data;
    logic [LANES-1:0]       in_mask, out_mask;
    logic [CNT_W-1:0]       stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clkf = ~clkf;

    lane_skid_reg #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clkf      (clkf),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .stall_cnt (stall_cnt)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clkf);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_mask = 4'hF;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 32'h12345678; in_mask = 4'hF;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (out_mask !== 4'h0) begin n_err++; $display("FAIL reset_out_mask got %h want 0", out_mask); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'h11223344; in_mask = 4'hF;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h11223344) begin n_err++; $display("FAIL stream_w0 got v=%b %h want v=1 11223344", out_valid, out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready0 got %b want 1", in_ready); end
        in_data = 32'h55667788;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h55667788) begin n_err++; $display("FAIL stream_w1 got v=%b %h want v=1 55667788", out_valid, out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready1 got %b want 1", in_ready); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got v=%b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_mask = 4'hF;
        in_data = 32'hAAAAAAAA;
        step();
        n_cmp++; if (in_ready !== 1'b1 || out_data !== 32'hAAAAAAAA) begin n_err++; $display("FAIL bp_one got rdy=%b %h want rdy=1 aaaaaaaa", in_ready, out_data); end
        in_data = 32'hBBBBBBBB;
        step();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hAAAAAAAA) begin n_err++; $display("FAIL bp_full_hold got v=%b %h want v=1 aaaaaaaa", out_valid, out_data); end
        step();
        n_cmp++; if (out_data !== 32'hAAAAAAAA || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold2 got %h rdy=%b want aaaaaaaa rdy=0", out_data, in_ready); end
        n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL bp_stall got %0d want 2", stall_cnt); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hBBBBBBBB) begin n_err++; $display("FAIL bp_second got v=%b %h want v=1 bbbbbbbb", out_valid, out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise got %b want 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got v=%b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 4'd2) begin n_err++; $display("FAIL bp_stall_final got %0d want 2", stall_cnt); end
    endtask

    task automatic test_masking();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 32'hDEADBEEF; in_mask = 4'b0101;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 32'h00AD00EF) begin n_err++; $display("FAIL mask_data got %h want 00ad00ef", out_data); end
        n_cmp++; if (out_mask !== 4'b0101) begin n_err++; $display("FAIL mask_mask got %b want 0101", out_mask); end
        step();
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_mask = 4'hF;
        in_data = 32'h0A0B0C0D; step();
        in_data = 32'h01020304; step();
        n_cmp++; if (in_ready !== 1'b0 || stall_cnt !== 4'd1) begin n_err++; $display("FAIL flush_pre got rdy=%b cnt=%0d want rdy=0 cnt=1", in_ready, stall_cnt); end
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hCCCCCCCC;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_flags got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        n_cmp++; if (out_data !== 32'h0 || out_mask !== 4'h0) begin n_err++; $display("FAIL flush_data got %h/%h want 0/0", out_data, out_mask); end
        n_cmp++; if (stall_cnt !== 4'd1) begin n_err++; $display("FAIL flush_stall got %0d want 1", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost%0d got v=%b data=%h want v=0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_reset_midtransfer();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_mask = 4'hF;
        in_data = 32'h99999999; step();
        in_data = 32'h77777777; step();
        reset = 1'b1; in_valid = 1'b0;
        step();
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || stall_cnt !== 4'd0) begin
            n_err++; $display("FAIL midreset got v=%b rdy=%b %h cnt=%0d want 0 1 0 0", out_valid, in_ready, out_data, stall_cnt);
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_drop got v=%b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_mask = 4'hF; in_data = 32'h5A5A5A5A;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                n_cmp++; if (stall_cnt !== 4'd14) begin n_err++; $display("FAIL sat_14 got %0d want 14", stall_cnt); end
            end
        end
        n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_20 got %0d want 15", stall_cnt); end
        n_cmp++; if (out_data !== 32'h5A5A5A5A) begin n_err++; $display("FAIL sat_hold got %h want 5a5a5a5a", out_data); end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_mask = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_masking();
        test_flush();
        test_reset_midtransfer();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
